uart_loader: RTL and testbench



---
 rtl/uart_loader_pkg.sv | 16 +
 rtl/byte_fifo.sv | 65 ++++++
 rtl/uart_loader.sv | 153 +++++++++++++++
 tb/tb_uart_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Imported by the loader top level and its input FIFO.
package uart_loader_pkg;

    // Loader modes: length prefix, image body, runtime, aborted
    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_PROG = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = 2;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO between the UART loader and the CPU input port.
// Head entry is presented combinationally from storage.
module byte_fifo
    import uart_loader_pkg::*;
#(
    parameter int FIFO_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_LOG2-1:0] r_wp;
    logic [FIFO_LOG2-1:0] r_rp;
    logic [FIFO_LOG2:0]   r_cnt;
    logic               w_pop;
    logic               w_push;

    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == (FIFO_LOG2+1)'(DEPTH));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = r_mem[r_rp];

    // Storage write; cleared on reset so the head reads 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wp] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: length-prefixed little-endian image into instruction
// memory, then runtime bytes into a FIFO for the CPU input instruction.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int FIFO_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rdata,
    input  logic              rdata_ready,
    input  logic              ferr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        in_data,
    output logic              in_valid,
    input  logic              in_ready,
    output logic              ovf
);

    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [23:0]       r_asm;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   r_len;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_ovf;

    logic [31:0]       w_word;
    logic              w_last;
    logic              w_img_done;
    logic              w_take;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic              w_drop;

    // The current byte completes the word in the upper lane
    assign w_word     = {rdata, r_asm};
    assign w_last     = (r_idx == IDX_W'(WORD_BYTES - 1));
    assign w_img_done = (r_cnt == r_len);
    assign w_take     = rdata_ready && !ferr &&
                        ((r_state == S_LEN) ||
                         (r_state == S_PROG && !w_img_done));
    assign w_push     = rdata_ready && !ferr && (r_state == S_RUN);
    assign w_pop      = in_ready && !w_empty;
    assign w_drop     = (r_state == S_RUN) && rdata_ready &&
                        (ferr || (w_full && !w_pop));

    // Mode register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_next;
        end
    end

    // Mode transitions; PROG leaves one cycle after the last write pulse
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LEN: begin
                if (rdata_ready) begin
                    if (ferr) begin
                        w_next = S_ERR;
                    end else if (w_last) begin
                        if (w_word > MAX_WORDS) begin
                            w_next = S_ERR;
                        end else if (w_word == '0) begin
                            w_next = S_RUN;
                        end else begin
                            w_next = S_PROG;
                        end
                    end
                end
            end
            S_PROG: begin
                if (w_img_done) begin
                    w_next = S_RUN;
                end else if (rdata_ready && ferr) begin
                    w_next = S_ERR;
                end
            end
            S_RUN:   w_next = S_RUN;
            S_ERR:   w_next = S_ERR;
        endcase
    end

    // Byte-lane assembly, length capture, word writes and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_asm   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_take) begin
                r_idx <= r_idx + 1'b1;
                if (!w_last) begin
                    r_asm[{r_idx, 3'b000} +: 8] <= rdata;
                end else if (r_state == S_LEN) begin
                    r_len <= w_word[ADDR_W:0];
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= r_cnt[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    byte_fifo #(
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (rdata),
        .pop   (w_pop),
        .dout  (in_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign load_done  = (r_state == S_RUN);
    assign load_err   = (r_state == S_ERR);
    assign in_valid   = !w_empty;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: image loading, error paths,
// runtime FIFO behaviour against a queue-based reference model.
module tb_uart_loader;

    localparam int AW    = 10;
    localparam int FL    = 4;
    localparam int DEPTH = 1 << FL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rdata = '0;
    logic          rdata_ready = 1'b0;
    logic          ferr = 1'b0;
    logic          in_ready = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          load_done;
    logic          load_err;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          ovf;

    int n_tot  = 0;
    int n_pass = 0;

    logic [AW+31:0] wr_q [$];
    logic [31:0]    img [$];

    uart_loader #(
        .ADDR_W    (AW),
        .FIFO_LOG2 (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdata       (rdata),
        .rdata_ready (rdata_ready),
        .ferr        (ferr),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .load_done   (load_done),
        .load_err    (load_err),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Log every instruction-memory write
    always @(posedge clk) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    end

    task automatic do_reset();
        rst = 1'b1;
        rdata_ready = 1'b0;
        ferr = 1'b0;
        in_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe,
                             input int gap);
        repeat (gap) @(negedge clk);
        rdata = b;
        ferr = fe;
        rdata_ready = 1'b1;
        @(negedge clk);
        rdata_ready = 1'b0;
        ferr = 1'b0;
        rdata = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0, gap);
    endtask

    task automatic load_image(input int gap);
        send_word(32'(img.size()), gap);
        n_tot++;
        if ({load_done, load_err} !== 2'b00)
            $display("FAIL len_state: got %b want 00", {load_done, load_err});
        else n_pass++;
        for (int i = 0; i < img.size(); i++) begin
            for (int b = 0; b < 4; b++)
                send_byte(img[i][8*b +: 8], 1'b0, gap);
            n_tot++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, AW'(i), img[i]})
                $display("FAIL write%0d: got we=%b a=%0d d=%h want a=%0d d=%h",
                         i, imem_we, imem_addr, imem_wdata, i, img[i]);
            else n_pass++;
        end
        n_tot++;
        if (load_done !== 1'b0)
            $display("FAIL done_early: got %b want 0", load_done);
        else n_pass++;
        @(negedge clk);
        n_tot++;
        if ({load_done, imem_we} !== 2'b10)
            $display("FAIL done_rise: got done/we %b want 10", {load_done, imem_we});
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_tot++;
        if ({imem_we, imem_addr, imem_wdata, load_done, load_err,
             in_data, in_valid, ovf} !== '0)
            $display("FAIL reset: got we=%b a=%h d=%h done=%b err=%b in=%h v=%b ovf=%b want all 0",
                     imem_we, imem_addr, imem_wdata, load_done, load_err,
                     in_data, in_valid, ovf);
        else n_pass++;
    endtask

    task automatic test_small_image();
        do_reset();
        img = '{32'h44332211, 32'h88776655};
        load_image(1);
    endtask

    task automatic test_random_image();
        int n;
        do_reset();
        n = $urandom_range(1, 8);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
        load_image($urandom_range(0, 3));
        @(negedge clk);
        n_tot++;
        if (wr_q.size() !== n)
            $display("FAIL rand_wcount: got %0d want %0d", wr_q.size(), n);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        do_reset();
        send_word(32'd0, 1);
        n_tot++;
        if ({load_done, imem_we} !== 2'b10)
            $display("FAIL zero_done: got done/we %b want 10", {load_done, imem_we});
        else n_pass++;
        send_byte(8'hA5, 1'b0, 1);
        n_tot++;
        if ({in_valid, in_data} !== {1'b1, 8'hA5})
            $display("FAIL zero_push: got v=%b d=%h want v=1 d=a5", in_valid, in_data);
        else n_pass++;
        n_tot++;
        if (wr_q.size() !== 0)
            $display("FAIL zero_nowrite: got %0d writes want 0", wr_q.size());
        else n_pass++;
    endtask

    task automatic test_ferr();
        do_reset();
        send_word(32'd1, 0);
        send_byte(8'h11, 1'b1, 0);
        n_tot++;
        if ({load_err, imem_we} !== 2'b10)
            $display("FAIL ferr_err: got err/we %b want 10", {load_err, imem_we});
        else n_pass++;
        for (int i = 0; i < 6; i++)
            send_byte(8'($urandom), 1'($urandom), 1);
        n_tot++;
        if ({load_err, load_done, in_valid, ovf} !== 4'b1000 || wr_q.size() != 0)
            $display("FAIL ferr_ignore: got err/done/v/ovf %b writes %0d want 1000 0",
                     {load_err, load_done, in_valid, ovf}, wr_q.size());
        else n_pass++;
    endtask

    task automatic test_len_limit();
        logic [31:0] big;
        do_reset();
        send_word((32'(1) << AW) + 32'd1, 0);
        n_tot++;
        if ({load_err, load_done} !== 2'b10)
            $display("FAIL len_over1: got err/done %b want 10", {load_err, load_done});
        else n_pass++;
        do_reset();
        big = (32'(1) << AW) + 32'd2 + ($urandom & 32'h7fff_ffff);
        send_word(big, 1);
        n_tot++;
        if ({load_err, load_done} !== 2'b10)
            $display("FAIL len_over_big: got err/done %b want 10 len=%h",
                     {load_err, load_done}, big);
        else n_pass++;
        do_reset();
        img.delete();
        for (int i = 0; i < (1 << AW); i++) img.push_back($urandom);
        load_image(0);
        @(negedge clk);
        n_tot++;
        if (wr_q.size() !== (1 << AW) || wr_q[$] !== {AW'((1 << AW) - 1), img[$]})
            $display("FAIL len_max: got %0d writes last %h want %0d last %h",
                     wr_q.size(), wr_q[$], 1 << AW, {AW'((1 << AW) - 1), img[$]});
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        do_reset();
        send_word(32'd0, 0);
        for (int i = 0; i <= DEPTH; i++) begin
            send_byte(8'(i), 1'b0, 1);
            if (i == DEPTH - 1) begin
                n_tot++;
                if ({ovf, in_valid, in_data} !== {2'b01, 8'h00})
                    $display("FAIL fill16: got ovf=%b v=%b d=%h want 0 1 00",
                             ovf, in_valid, in_data);
                else n_pass++;
            end
        end
        n_tot++;
        if (ovf !== 1'b1)
            $display("FAIL ovf17: got %b want 1", ovf);
        else n_pass++;
        in_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_tot++;
            if ({in_valid, in_data} !== {1'b1, 8'(i)})
                $display("FAIL pop%0d: got v=%b d=%h want v=1 d=%h",
                         i, in_valid, in_data, 8'(i));
            else n_pass++;
            @(negedge clk);
        end
        in_ready = 1'b0;
        n_tot++;
        if (in_valid !== 1'b0)
            $display("FAIL drained: got v=%b want 0", in_valid);
        else n_pass++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] got [$];
        int bad;
        do_reset();
        send_word(32'd0, 0);
        for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i), 1'b0, 0);
        rdata = 8'h99;
        rdata_ready = 1'b1;
        in_ready = 1'b1;
        @(negedge clk);
        rdata_ready = 1'b0;
        in_ready = 1'b0;
        n_tot++;
        if ({ovf, in_valid, in_data} !== {2'b01, 8'h41})
            $display("FAIL pp_full: got ovf=%b v=%b d=%h want 0 1 41",
                     ovf, in_valid, in_data);
        else n_pass++;
        in_ready = 1'b1;
        for (int k = 0; k < DEPTH + 4; k++) begin
            if (!in_valid) break;
            got.push_back(in_data);
            @(negedge clk);
        end
        in_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (i < DEPTH - 1 && got[i] !== 8'h41 + 8'(i)) bad++;
            if (i == DEPTH - 1 && got[i] !== 8'h99) bad++;
        end
        n_tot++;
        if (got.size() !== DEPTH || bad != 0)
            $display("FAIL pp_count: got %0d entries %0d wrong want %0d 0",
                     got.size(), bad, DEPTH);
        else n_pass++;
    endtask

    task automatic test_random_run();
        logic [7:0] q [$];
        logic movf;
        logic s, fe, rdy, pop, push;
        logic [7:0] b;
        do_reset();
        send_word(32'd0, 0);
        movf = 1'b0;
        for (int c = 0; c < 300; c++) begin
            s   = 1'($urandom);
            b   = 8'($urandom);
            fe  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            rdata = b;
            ferr = fe;
            rdata_ready = s;
            in_ready = rdy;
            pop  = rdy && (q.size() > 0);
            push = 1'b0;
            if (s && fe) movf = 1'b1;
            else if (s) begin
                if (q.size() < DEPTH || pop) push = 1'b1;
                else movf = 1'b1;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(b);
            @(negedge clk);
            rdata_ready = 1'b0;
            ferr = 1'b0;
            in_ready = 1'b0;
            n_tot++;
            if (in_valid !== (q.size() > 0) || ovf !== movf)
                $display("FAIL run%0d: got v=%b ovf=%b want v=%b ovf=%b",
                         c, in_valid, ovf, q.size() > 0, movf);
            else n_pass++;
            if (q.size() > 0) begin
                n_tot++;
                if (in_data !== q[0])
                    $display("FAIL run_data%0d: got %h want %h", c, in_data, q[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_word(32'd1, 0);
        send_byte(8'hDE, 1'b0, 0);
        send_byte(8'hAD, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        n_tot++;
        if ({imem_we, imem_addr, imem_wdata, load_done, load_err,
             in_data, in_valid, ovf} !== '0)
            $display("FAIL midrst: got we=%b a=%h d=%h done=%b err=%b want all 0",
                     imem_we, imem_addr, imem_wdata, load_done, load_err);
        else n_pass++;
        img.delete();
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        load_image(1);
    endtask

    initial begin
        test_reset();
        test_small_image();
        test_random_image();
        test_zero_len();
        test_ferr();
        test_len_limit();
        test_fifo_full();
        test_push_pop_full();
        test_random_run();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
